// File: rtl/dbus_arbiter.sv
// Two-master, one-slave data bus arbiter: round-robin grant with stall lock,
// zero added request latency, and in-order read response routing via an id FIFO.
module dbus_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned OSTD_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic                          m0_req,
    input  logic                          m0_write,
    input  logic [XLEN/8-1:0]             m0_wstrb,
    input  logic [XLEN-1:0]               m0_addr,
    input  logic [XLEN-1:0]               m0_wdata,
    output logic                          m0_ready,
    output logic                          m0_rvalid,
    output logic [XLEN-1:0]               m0_rdata,
    input  logic                          m1_req,
    input  logic                          m1_write,
    input  logic [XLEN/8-1:0]             m1_wstrb,
    input  logic [XLEN-1:0]               m1_addr,
    input  logic [XLEN-1:0]               m1_wdata,
    output logic                          m1_ready,
    output logic                          m1_rvalid,
    output logic [XLEN-1:0]               m1_rdata,
    output logic                          s_req,
    output logic                          s_write,
    output logic [XLEN/8-1:0]             s_wstrb,
    output logic [XLEN-1:0]               s_addr,
    output logic [XLEN-1:0]               s_wdata,
    input  logic                          s_ready,
    input  logic                          s_rvalid,
    input  logic [XLEN-1:0]               s_rdata,
    output logic [$clog2(OSTD_DEPTH):0]   ostd_cnt,
    output logic                          rsp_err
);

    localparam int unsigned PW = $clog2(OSTD_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic                  prio_q;
    logic                  lock_q;
    logic                  owner_q;
    logic [OSTD_DEPTH-1:0] fifo_q;
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         cnt_q;
    logic                  rsp_err_q;

    logic gnt_vld;
    logic gnt_id;
    logic full;
    logic read_block;
    logic accept;
    logic push;
    logic pop;
    logic head;

    // Grant: a locked owner keeps the bus; otherwise single requester or round-robin
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 1'b0;
        if (lock_q) begin
            gnt_id  = owner_q;
            gnt_vld = owner_q ? m1_req : m0_req;
        end else if (m0_req && m1_req) begin
            gnt_vld = 1'b1;
            gnt_id  = prio_q;
        end else if (m0_req || m1_req) begin
            gnt_vld = 1'b1;
            gnt_id  = m1_req;
        end
    end

    // Request mux toward the target; zero when nobody is granted
    always_comb begin
        s_write = 1'b0;
        s_wstrb = '0;
        s_addr  = '0;
        s_wdata = '0;
        if (gnt_vld) begin
            if (gnt_id) begin
                s_write = m1_write;
                s_wstrb = m1_wstrb;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
            end else begin
                s_write = m0_write;
                s_wstrb = m0_wstrb;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
            end
        end
    end

    // A full id FIFO blocks reads even if a response frees a slot this cycle
    assign full       = (cnt_q == CW'(OSTD_DEPTH));
    assign read_block = gnt_vld && !s_write && full;
    assign s_req      = gnt_vld && !read_block;
    assign accept     = s_req && s_ready;
    assign m0_ready   = accept && !gnt_id;
    assign m1_ready   = accept && gnt_id;

    assign push      = accept && !s_write;
    assign pop       = s_rvalid && (cnt_q != '0);
    assign head      = fifo_q[rd_ptr_q];
    assign m0_rvalid = pop && !head;
    assign m1_rvalid = pop && head;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign ostd_cnt  = cnt_q;
    assign rsp_err   = rsp_err_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            prio_q    <= 1'b0;
            lock_q    <= 1'b0;
            owner_q   <= 1'b0;
            fifo_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                prio_q <= !gnt_id;
            end
            // A locked owner that withdraws its request releases the lock
            if (accept || (lock_q && !gnt_vld)) begin
                lock_q <= 1'b0;
            end else if (s_req && !s_ready) begin
                lock_q  <= 1'b1;
                owner_q <= gnt_id;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= gnt_id;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (s_rvalid && (cnt_q == '0)) begin
                rsp_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Testbench for dbus_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the arbiter.
module tb_dbus_arbiter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic              clk;
    logic              rst_b;
    logic              m0_req, m0_write, m0_ready, m0_rvalid;
    logic [3:0]        m0_wstrb;
    logic [XLEN-1:0]   m0_addr, m0_wdata, m0_rdata;
    logic              m1_req, m1_write, m1_ready, m1_rvalid;
    logic [3:0]        m1_wstrb;
    logic [XLEN-1:0]   m1_addr, m1_wdata, m1_rdata;
    logic              s_req, s_write, s_ready, s_rvalid;
    logic [3:0]        s_wstrb;
    logic [XLEN-1:0]   s_addr, s_wdata, s_rdata;
    logic [2:0]        ostd_cnt;
    logic              rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    dbus_arbiter #(.XLEN(XLEN), .OSTD_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_b(rst_b),
        .m0_req(m0_req), .m0_write(m0_write), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_write(s_write), .s_wstrb(s_wstrb), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .ostd_cnt(ostd_cnt), .rsp_err(rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        m0_req = 0; m0_write = 0; m0_wstrb = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_write = 0; m1_wstrb = '0; m1_addr = '0; m1_wdata = '0;
        s_ready = 0; s_rvalid = 0; s_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++;
        if ({s_req, m0_ready, m1_ready, m0_rvalid, m1_rvalid, ostd_cnt, rsp_err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 00000000",
                     {s_req, m0_ready, m1_ready, m0_rvalid, m1_rvalid, ostd_cnt, rsp_err});
        end
        next_cycle();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_req = 1; m0_addr = 32'h100; s_ready = 1;
        @(negedge clk);
        n_tests++;
        if ({s_req, m0_ready, s_addr} !== {2'b11, 32'h100}) begin
            n_fail++;
            $display("FAIL single_accept: got req/ready=%b%b addr=%h expected 11 addr=00000100",
                     s_req, m0_ready, s_addr);
        end
        next_cycle();
        idle();
        s_rvalid = 1; s_rdata = 32'hDEADBEEF;
        @(negedge clk);
        n_tests++;
        if ({m0_rvalid, m1_rvalid, m0_rdata, ostd_cnt} !== {2'b10, 32'hDEADBEEF, 3'd1}) begin
            n_fail++;
            $display("FAIL single_resp: got v0=%b v1=%b rdata=%h cnt=%0d expected 1 0 deadbeef 1",
                     m0_rvalid, m1_rvalid, m0_rdata, ostd_cnt);
        end
        next_cycle();
        idle();
        @(negedge clk);
        n_tests++;
        if (ostd_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL single_drain: got cnt=%0d expected 0", ostd_cnt);
        end
        next_cycle();
    endtask

    task automatic test_contention();
        logic [1:0] got, exp;
        do_reset();
        m0_req = 1; m0_write = 1; m0_addr = 32'hA0;
        m1_req = 1; m1_write = 1; m1_addr = 32'hB0;
        s_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            got = {m1_ready, m0_ready};
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL contention_%0d: got {m1,m0}_ready=%b expected %b", i, got, exp);
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_stall_lock();
        do_reset();
        m1_req = 1; m1_write = 1; m1_addr = 32'hB1B1; s_ready = 0;
        m0_write = 1; m0_addr = 32'hA0A0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) m0_req = 1;
            if (i == 3) s_ready = 1;
            @(negedge clk);
            n_tests++;
            if ({s_addr, m1_ready, m0_ready} !== {32'hB1B1, (i == 3), 1'b0}) begin
                n_fail++;
                $display("FAIL stall_lock_%0d: got addr=%h m1_ready=%b m0_ready=%b expected b1b1 %b 0",
                         i, s_addr, m1_ready, m0_ready, (i == 3));
            end
            next_cycle();
        end
        m1_req = 0;
        @(negedge clk);
        n_tests++;
        if ({s_addr, m0_ready} !== {32'hA0A0, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_after: got addr=%h m0_ready=%b expected a0a0 1", s_addr, m0_ready);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_ordering();
        logic [2:0] ids;
        ids = 3'b010;
        do_reset();
        s_ready = 1;
        for (int i = 0; i < 3; i++) begin
            m0_req = !ids[i]; m1_req = ids[i];
            m0_addr = 32'h10 + 32'(i); m1_addr = 32'h20 + 32'(i);
            @(negedge clk);
            n_tests++;
            if ({m1_ready, m0_ready} !== {ids[i], !ids[i]}) begin
                n_fail++;
                $display("FAIL order_accept_%0d: got {m1,m0}_ready=%b%b expected %b%b",
                         i, m1_ready, m0_ready, ids[i], !ids[i]);
            end
            next_cycle();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            s_rvalid = 1; s_rdata = 32'(i + 1);
            @(negedge clk);
            n_tests++;
            if ({m1_rvalid, m0_rvalid, ostd_cnt} !== {ids[i], !ids[i], 3'(3 - i)} ||
                (ids[i] ? m1_rdata : m0_rdata) !== 32'(i + 1)) begin
                n_fail++;
                $display("FAIL order_resp_%0d: got {v1,v0}=%b%b cnt=%0d d0=%h d1=%h expected %b%b %0d data %0d",
                         i, m1_rvalid, m0_rvalid, ostd_cnt, m0_rdata, m1_rdata,
                         ids[i], !ids[i], 3 - i, i + 1);
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_full();
        do_reset();
        m0_req = 1; s_ready = 1;
        repeat (4) next_cycle();
        @(negedge clk);
        n_tests++;
        if ({s_req, m0_ready, ostd_cnt} !== {2'b00, 3'd4}) begin
            n_fail++;
            $display("FAIL full_block: got s_req=%b m0_ready=%b cnt=%0d expected 0 0 4",
                     s_req, m0_ready, ostd_cnt);
        end
        next_cycle();
        m1_req = 1; m1_write = 1; m1_addr = 32'hC0;
        @(negedge clk);
        n_tests++;
        if ({m1_ready, m0_ready, s_write} !== 3'b101) begin
            n_fail++;
            $display("FAIL full_write: got m1_ready=%b m0_ready=%b s_write=%b expected 1 0 1",
                     m1_ready, m0_ready, s_write);
        end
        next_cycle();
        m1_req = 0; m1_write = 0; s_rvalid = 1;
        @(negedge clk);
        n_tests++;
        if ({s_req, m0_ready, m0_rvalid} !== 3'b001) begin
            n_fail++;
            $display("FAIL full_pop_block: got s_req=%b m0_ready=%b m0_rvalid=%b expected 0 0 1",
                     s_req, m0_ready, m0_rvalid);
        end
        next_cycle();
        s_rvalid = 0;
        @(negedge clk);
        n_tests++;
        if ({m0_ready, ostd_cnt} !== {1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL full_resume: got m0_ready=%b cnt=%0d expected 1 3", m0_ready, ostd_cnt);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_error_reset();
        do_reset();
        s_rvalid = 1;
        @(negedge clk);
        n_tests++;
        if ({m0_rvalid, m1_rvalid, rsp_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL err_drop: got v0=%b v1=%b err=%b expected 0 0 0", m0_rvalid, m1_rvalid, rsp_err);
        end
        next_cycle();
        s_rvalid = 0;
        repeat (3) next_cycle();
        @(negedge clk);
        n_tests++;
        if ({rsp_err, ostd_cnt} !== {1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b cnt=%0d expected 1 0", rsp_err, ostd_cnt);
        end
        next_cycle();
        // m1 read (prio -> m0), then lock m1 by stalling, then m0 joins
        m1_req = 1; m1_addr = 32'hB2; s_ready = 1;
        next_cycle();
        s_ready = 0;
        next_cycle();
        m0_req = 1; m0_addr = 32'hA2;
        @(negedge clk);
        n_tests++;
        if ({s_addr, ostd_cnt} !== {32'hB2, 3'd1}) begin
            n_fail++;
            $display("FAIL err_locked: got addr=%h cnt=%0d expected 000000b2 1", s_addr, ostd_cnt);
        end
        @(posedge clk);
        #2 rst_b = 0;
        #1;
        n_tests++;
        if ({rsp_err, ostd_cnt, s_addr} !== {1'b0, 3'd0, 32'hA2}) begin
            n_fail++;
            $display("FAIL async_reset: got err=%b cnt=%0d addr=%h expected 0 0 000000a2",
                     rsp_err, ostd_cnt, s_addr);
        end
        next_cycle();
        rst_b = 1;
        idle();
    endtask

    task automatic test_random();
        bit q[$];
        bit pr, lk, own, err;
        bit r[2], w[2];
        logic [XLEN-1:0] a[2], d[2];
        logic [3:0] st[2];
        bit gv, g, blocked, sreq, acc, rv;
        logic [77:0] exp_v, got_v;
        pr = 0; lk = 0; own = 0; err = 0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            m0_req = ($urandom_range(0, 3) != 0); m0_write = $urandom_range(0, 1) == 1;
            m0_addr = $urandom; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
            m1_req = ($urandom_range(0, 3) != 0); m1_write = $urandom_range(0, 1) == 1;
            m1_addr = $urandom; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
            s_ready = ($urandom_range(0, 3) != 0);
            s_rvalid = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 150) == 0);
            s_rdata = $urandom;
            r[0] = m0_req; w[0] = m0_write; a[0] = m0_addr; d[0] = m0_wdata; st[0] = m0_wstrb;
            r[1] = m1_req; w[1] = m1_write; a[1] = m1_addr; d[1] = m1_wdata; st[1] = m1_wstrb;
            if (lk) begin
                g = own; gv = r[own];
            end else if (r[0] && r[1]) begin
                g = pr; gv = 1;
            end else begin
                g = r[1]; gv = r[0] || r[1];
            end
            blocked = gv && !w[g] && (q.size() == DEPTH);
            sreq = gv && !blocked;
            acc  = sreq && s_ready;
            rv   = s_rvalid && (q.size() != 0);
            exp_v = {sreq, acc && !g, acc && g, rv && (q[0] == 0), rv && (q[0] == 1),
                     gv ? w[g] : 1'b0, gv ? st[g] : 4'h0, gv ? a[g] : 32'h0, gv ? d[g] : 32'h0,
                     3'(q.size()), err};
            @(negedge clk);
            got_v = {s_req, m0_ready, m1_ready, m0_rvalid, m1_rvalid, s_write, s_wstrb,
                     s_addr, s_wdata, ostd_cnt, rsp_err};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got %h expected %h", cyc, got_v, exp_v);
            end
            if (s_rvalid && q.size() == 0) err = 1;
            if (rv) void'(q.pop_front());
            if (acc && !w[g]) q.push_back(g);
            if (acc) begin
                lk = 0; pr = !g;
            end else if (lk && !gv) begin
                lk = 0;
            end else if (sreq && !s_ready) begin
                lk = 1; own = g;
            end
            next_cycle();
        end
        idle();
    endtask

    initial begin
        rst_b = 1'b0;
        idle();
        test_reset();
        test_single_read();
        test_contention();
        test_stall_lock();
        test_ordering();
        test_full();
        test_error_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
